// File: rtl/wallace_mult_pipe_pkg.sv
// rtl/wallace_mult_pipe_pkg.sv - shared types and tree-sizing helpers for the pipelined Wallace multiplier
// Contents: mult_mode_e operand mode, DEFAULT_WIDTH, rows_after()/csa_levels() row-count helpers.
package wtree_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mult_mode_e;

  localparam int DEFAULT_WIDTH = 16;

  // Rows left after 'levels' rounds of 3:2 compression starting from n rows.
  function automatic int rows_after(int n, int levels);
    int r;
    r = n;
    for (int i = 0; i < levels; i++) begin
      r = 2 * (r / 3) + (r % 3);
    end
    return r;
  endfunction

  // Number of Wallace rows (3:2 levels) needed to bring n partial products down to two.
  function automatic int csa_levels(int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2 * (r / 3) + (r % 3);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/wallace_mult_pipe_if.sv
// rtl/wallace_mult_pipe_if.sv - operand/result handshake bundle for wallace_mult_pipe
// Signals: Clear (flush), In_valid/In_ready with MUR, MUD, Signed_mode, Acc_first;
//          Out_valid/Out_ready with Result. slave = multiplier side, master = sequencer/writeback side.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = wtree_pkg::DEFAULT_WIDTH,
  parameter int RES_W = 2 * WIDTH
);
  logic             Clear;
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] MUR;
  logic [WIDTH-1:0] MUD;
  logic             Signed_mode;
  logic             Acc_first;
  logic             Out_valid;
  logic             Out_ready;
  logic [RES_W-1:0] Result;

  modport master (
    output Clear, In_valid, MUR, MUD, Signed_mode, Acc_first, Out_ready,
    input  In_ready, Out_valid, Result
  );

  modport slave (
    input  Clear, In_valid, MUR, MUD, Signed_mode, Acc_first, Out_ready,
    output In_ready, Out_valid, Result
  );
endinterface

// File: rtl/wallace_mult_pipe_csa_3to2.sv
// rtl/wallace_mult_pipe_csa_3to2.sv - one W-bit 3:2 carry-save compressor row
// Ports: a, b, c (in, W) rows to compress; sum (out, W); carry (out, W) already weighted one bit up.
module csa_3to2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);
  assign sum = a ^ b ^ c;
  // The carry out of the top bit falls outside the 2*WIDTH product and is dropped (mod 2^W).
  assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
endmodule

// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - pipelined, parametrised Wallace-tree multiplier with valid/ready handshake
// Ports: Clk (in) rising-edge clock; Reset_n (in) async active-low reset;
//        bus (wallace_mult_pipe_if.slave) Clear, In_valid/In_ready, MUR, MUD, Signed_mode, Acc_first,
//        Out_valid/Out_ready, Result.
// Option: define WTREE_ACCUM_EN to add a RES_W-bit accumulator in the final stage.
module wallace_mult_pipe
  import wtree_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_GUARD   = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  wallace_mult_pipe_if.slave bus
);
  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = csa_levels(WIDTH);

  // The whole pipe moves in lockstep; bubbles stay where they are.
  logic adv;
  logic take;
  logic [PIPE_STAGES-1:0] vld_in;
  logic [PIPE_STAGES-1:0] vld_q;

  assign adv          = ~vld_q[PIPE_STAGES-1] | bus.Out_ready;
  assign bus.In_ready = Reset_n & adv & ~bus.Clear;
  assign take         = bus.In_valid & bus.In_ready;
  assign bus.Out_valid = vld_q[PIPE_STAGES-1];

  // Partial products. Signed mode is Baugh-Wooley: terms with exactly one sign bit are inverted and
  // the correction constants 2^WIDTH + 2^(2*WIDTH-1) ride in row 0's otherwise empty upper bits.
  mult_mode_e    mode;
  logic [PW-1:0] pp [WIDTH];

  assign mode = mult_mode_e'(bus.Signed_mode);

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (bus.MUR[i] & bus.MUD[j]) ^
                     ((mode == MODE_SIGNED) && ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    if (mode == MODE_SIGNED) begin
      pp[0][WIDTH] = 1'b1;
      pp[0][PW-1]  = 1'b1;
    end
  end

  // Each stage applies its share of tree levels; every stage carries WIDTH row slots,
  // slots beyond the live row count are tied to zero.
  logic [PW-1:0] rows_d [PIPE_STAGES][WIDTH];
  logic [PW-1:0] rows_q [PIPE_STAGES][WIDTH];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    localparam int LO = (k * LEVELS) / PIPE_STAGES;
    localparam int NL = ((k + 1) * LEVELS) / PIPE_STAGES - LO;
    logic [PW-1:0] lv [NL+1][WIDTH];

    if (k == 0) begin : g_head
      assign lv[0]     = pp;
      assign vld_in[k] = take;
    end else begin : g_body
      assign lv[0]     = rows_q[k-1];
      assign vld_in[k] = vld_q[k-1];
    end

    for (genvar j = 0; j < NL; j++) begin : g_lvl
      localparam int N   = rows_after(WIDTH, LO + j);
      localparam int G   = N / 3;
      localparam int REM = N - 3 * G;
      for (genvar g = 0; g < G; g++) begin : g_csa
        csa_3to2 #(.W(PW)) u_csa (
          .a    (lv[j][3*g]),
          .b    (lv[j][3*g+1]),
          .c    (lv[j][3*g+2]),
          .sum  (lv[j+1][2*g]),
          .carry(lv[j+1][2*g+1])
        );
      end
      // Rows left over from grouping pass straight through behind the compressed pairs.
      for (genvar o = 2 * G; o < WIDTH; o++) begin : g_pass
        if (o < 2 * G + REM) begin : g_keep
          assign lv[j+1][o] = lv[j][o+G];
        end else begin : g_zero
          assign lv[j+1][o] = '0;
        end
      end
    end

    assign rows_d[k] = lv[NL];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        for (int r = 0; r < WIDTH; r++) begin
          rows_q[k][r] <= '0;
        end
      end
    end else if (bus.Clear) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q  <= vld_in;
      rows_q <= rows_d;
    end
  end

`ifdef WTREE_ACCUM_EN
  localparam int RES_W = PW + ACC_GUARD;

  // Mode and Acc_first follow their operands so the accumulate step sees the right transaction.
  logic [PIPE_STAGES-1:0] mode_in;
  logic [PIPE_STAGES-1:0] mode_q;
  logic [PIPE_STAGES-1:0] first_in;
  logic [PIPE_STAGES-1:0] first_q;
  logic [PW-1:0]          prod;
  logic [RES_W-1:0]       prod_ext;
  logic [RES_W-1:0]       acc_q;

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_tag
    if (k == 0) begin : g_head
      assign mode_in[k]  = bus.Signed_mode;
      assign first_in[k] = bus.Acc_first;
    end else begin : g_body
      assign mode_in[k]  = mode_q[k-1];
      assign first_in[k] = first_q[k-1];
    end
  end

  // Final carry-propagate add happens before the accumulator register.
  assign prod     = rows_d[PIPE_STAGES-1][0] + rows_d[PIPE_STAGES-1][1];
  assign prod_ext = {{ACC_GUARD{prod[PW-1] & mode_in[PIPE_STAGES-1]}}, prod};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode_q  <= '0;
      first_q <= '0;
      acc_q   <= '0;
    end else if (bus.Clear) begin
      acc_q <= '0;
    end else if (adv) begin
      mode_q  <= mode_in;
      first_q <= first_in;
      if (vld_in[PIPE_STAGES-1]) begin
        acc_q <= (first_in[PIPE_STAGES-1] ? '0 : acc_q) + prod_ext;
      end
    end
  end

  assign bus.Result = acc_q;
`else
  logic unused_acc_first;
  assign unused_acc_first = bus.Acc_first;

  // Final carry-propagate add sits after the last register; reset rows give Result = 0.
  assign bus.Result = rows_q[PIPE_STAGES-1][0] + rows_q[PIPE_STAGES-1][1];
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb/tb_wallace_mult_pipe.sv - directed self-checking bench for wallace_mult_pipe (WIDTH=16, PIPE_STAGES=3)
module tb_wallace_mult_pipe;
  localparam int W = 16;
`ifdef WTREE_ACCUM_EN
  localparam int RES_W = 2 * W + 8;
  localparam bit ACCUM = 1'b1;
`else
  localparam int RES_W = 2 * W;
  localparam bit ACCUM = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  wallace_mult_pipe_if #(.WIDTH(W), .RES_W(RES_W)) bus ();

  wallace_mult_pipe #(.WIDTH(W), .PIPE_STAGES(3), .ACC_GUARD(8)) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected Result for a 32-bit product; the accumulating build sign-extends signed products.
  function automatic logic [63:0] full(input logic [31:0] p, input logic s);
    if (ACCUM && s) return {{32{p[31]}}, p} & ((64'd1 << RES_W) - 64'd1);
    return {32'd0, p};
  endfunction

  // One isolated transaction: checks acceptance, latency and product.
  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic first, input logic [63:0] exp, input string tag);
    int lat;
    @(negedge clk);
    bus.MUR = a; bus.MUD = b; bus.Signed_mode = s; bus.Acc_first = first;
    bus.In_valid = 1'b1; bus.Out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, bus.In_ready, 1);
    @(negedge clk);
    bus.In_valid = 1'b0;
    lat = 1;
    while (!bus.Out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_res"}, bus.Result, exp);
  endtask

  logic [15:0] sa [5];
  logic [31:0] sp [5];
  logic [63:0] got [$];
  int idx;
  int seen;

  initial begin
    sa = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
    sp = '{32'h1133, 32'h2266, 32'h3399, 32'h44CC, 32'h55FF};
    rst_n = 1'b0;
    bus.Clear = 1'b0; bus.In_valid = 1'b0; bus.MUR = '0; bus.MUD = '0;
    bus.Signed_mode = 1'b0; bus.Acc_first = 1'b1; bus.Out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_out_valid", bus.Out_valid, 0);
    chk("reset_result", bus.Result, 0);
    chk("reset_in_ready", bus.In_ready, 0);
    rst_n = 1'b1;
    #1 chk("release_in_ready", bus.In_ready, 1);

    // Basic product and arithmetic corners
    single(16'h0101, 16'h0101, 1'b0, 1'b1, full(32'h00010201, 1'b0), "t1_0101sq");
    single(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, full(32'hFFFE0001, 1'b0), "t2_max_u");
    single(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, full(32'h00000001, 1'b1), "t2_max_s");
    single(16'h8000, 16'h7FFF, 1'b1, 1'b1, full(32'hC0008000, 1'b1), "t2_minmax_s");
    single(16'h8000, 16'h7FFF, 1'b0, 1'b1, full(32'h3FFF8000, 1'b0), "t2_minmax_u");
    single(16'h8000, 16'h8000, 1'b1, 1'b1, full(32'h40000000, 1'b1), "t2_minmin_s");
    single(16'h0000, 16'hFFFF, 1'b0, 1'b1, full(32'h00000000, 1'b0), "t2_zero_u");
    single(16'h1234, 16'hFFFE, 1'b1, 1'b1, full(32'hFFFFDB98, 1'b1), "t2_neg2_s");
    single(16'h1234, 16'h5678, 1'b0, 1'b1, full(32'h06260060, 1'b0), "t2_mixed_u");

    // Backpressure: Out_ready low for 6 cycles while streaming 5 ops
    idx = 0;
    got.delete();
    for (int cyc = 0; cyc < 40 && got.size() < 5; cyc++) begin
      @(negedge clk);
      bus.Out_ready = (cyc >= 6);
      bus.In_valid  = (idx < 5);
      if (idx < 5) begin
        bus.MUR = sa[idx]; bus.MUD = 16'h0103; bus.Signed_mode = 1'b0; bus.Acc_first = 1'b1;
      end
      #1;
      if (cyc == 5) begin
        chk("bp_accepted", idx, 3);
        chk("bp_in_ready", bus.In_ready, 0);
        chk("bp_hold_valid", bus.Out_valid, 1);
        chk("bp_hold_result", bus.Result, full(sp[0], 1'b0));
      end
      if (bus.Out_valid && bus.Out_ready) got.push_back(64'(bus.Result));
      if (bus.In_valid && bus.In_ready) idx++;
    end
    bus.In_valid = 1'b0;
    chk("bp_count", got.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 64'hx, full(sp[i], 1'b0));
    end

    // Clear with two ops in flight and In_valid high
    bus.Out_ready = 1'b1;
    @(negedge clk);
    bus.MUR = 16'h0002; bus.MUD = 16'h0003; bus.In_valid = 1'b1;
    @(negedge clk);
    bus.MUR = 16'h0004; bus.MUD = 16'h0005;
    @(negedge clk);
    bus.MUR = 16'h0006; bus.MUD = 16'h0007; bus.Clear = 1'b1;
    #1 chk("clr_in_ready", bus.In_ready, 0);
    @(negedge clk);
    bus.Clear = 1'b0; bus.In_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      if (bus.Out_valid) seen++;
      @(negedge clk);
    end
    chk("clr_no_output", seen, 0);
    single(16'h0123, 16'h0045, 1'b0, 1'b1, full(32'h00004E6F, 1'b0), "clr_next");

    // Reset pulse mid-stream
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.MUR = 16'h0100 + 16'(i); bus.MUD = 16'h0010; bus.Signed_mode = 1'b0; bus.In_valid = 1'b1;
    end
    @(negedge clk);
    bus.In_valid = 1'b0;
    chk("rst_mid_busy", bus.Out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.Out_valid, 0);
    chk("rst_mid_result", bus.Result, 0);
    chk("rst_mid_in_ready", bus.In_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    single(16'hFFFF, 16'h0002, 1'b1, 1'b1, full(32'hFFFFFFFE, 1'b1), "rst_restart");

`ifdef WTREE_ACCUM_EN
    // Accumulation
    single(16'h0002, 16'h0003, 1'b0, 1'b1, 64'd6, "acc_first");
    single(16'h0002, 16'h0003, 1'b0, 1'b0, 64'd12, "acc_second");
    single(16'h0002, 16'h0003, 1'b0, 1'b0, 64'd18, "acc_third");
    single(16'h0001, 16'h0001, 1'b0, 1'b1, 64'd1, "acc_restart");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
